// File: rtl/riscv_multicycle_ctrl_if.sv
// riscv_multicycle_ctrl_if
// Bundles the controller <-> datapath signals of the multi-cycle RV32I core.
//   Datapath -> controller: op, funct3, funct7b5 (from the instruction register),
//                           zero (ALU flag), mem_ready (shared memory port)
//   Controller -> datapath: register enables, memory strobe, mux selects,
//                           immediate format, ALU operation, illegal pulse
// master = controller side, slave = datapath side.
interface riscv_multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, ir_write, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, ir_write, mem_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
// Moore-style main controller for a multi-cycle RV32I subset core sharing one
// memory port between fetch and data access.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - riscv_multicycle_ctrl_if.master (decode inputs, control outputs)
//
// state    | meaning
// ---------+--------------------------------------------------------
// FETCH    | read instr at PC, PC <- PC+4 when memory is ready
// DECODE   | ALUOut <- old PC + imm (branch/jump target)
// MEMADR   | ALUOut <- rs1 + imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <- read data
// MEMWRITE | write rs2 to memory at ALUOut
// EXECR    | ALUOut <- rs1 op rs2
// EXECI    | ALUOut <- rs1 op imm
// ALUWB    | rd <- ALUOut
// JAL      | PC <- target, ALUOut <- old PC + 4
// BEQ      | compare rs1/rs2, PC <- target if equal
module riscv_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          rst_n,
    riscv_multicycle_ctrl_if.master       bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;

    logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;
    logic       adr_src_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, imm_src_c;
    logic [2:0] alu_control_c;

    // Only R-type (op[5]=1) with funct7b5 selects sub; addi ignores bit 30.
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic op5,
                                           input logic f7b5);
        case (f3)
            3'b000:  alu_dec = (op5 & f7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_dec = 3'b101;
            3'b110:  alu_dec = 3'b011;
            3'b111:  alu_dec = 3'b010;
            default: alu_dec = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        illegal_d     = 1'b0;
        pc_write_c    = 1'b0;
        ir_write_c    = 1'b0;
        mem_write_c   = 1'b0;
        reg_write_c   = 1'b0;
        adr_src_c     = 1'b0;
        result_src_c  = 2'b00;
        alu_src_a_c   = 2'b00;
        alu_src_b_c   = 2'b00;
        alu_control_c = 3'b000;

        case (state_q)
            S_FETCH: begin
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                ir_write_c   = bus.mem_ready;
                pc_write_c   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100011:             state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a_c   = 2'b10;
                alu_control_c = alu_dec(bus.funct3, bus.op[5], bus.funct7b5);
                state_d       = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c   = 2'b10;
                alu_src_b_c   = 2'b01;
                alu_control_c = alu_dec(bus.funct3, bus.op[5], bus.funct7b5);
                state_d       = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a_c   = 2'b10;
                alu_control_c = 3'b001;
                pc_write_c    = bus.zero;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (bus.op)
            7'b0100011: imm_src_c = 2'b01;
            7'b1100011: imm_src_c = 2'b10;
            7'b1101111: imm_src_c = 2'b11;
            default:    imm_src_c = 2'b00;
        endcase
    end

    // Strobes are gated by reset directly so no write can slip out while the
    // asynchronous state reset is still in flight.
    assign bus.pc_write    = pc_write_c  & rst_n;
    assign bus.ir_write    = ir_write_c  & rst_n;
    assign bus.mem_write   = mem_write_c & rst_n;
    assign bus.reg_write   = reg_write_c & rst_n;
    assign bus.adr_src     = adr_src_c;
    assign bus.result_src  = result_src_c;
    assign bus.alu_src_a   = alu_src_a_c;
    assign bus.alu_src_b   = alu_src_b_c;
    assign bus.imm_src     = imm_src_c;
    assign bus.alu_control = alu_control_c;
    assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench: each instruction pushes per-cycle stimulus together with
// the expected control vector; the runner pops one step per clock, drives it
// on the falling edge and compares the outputs 1 ns later.
module tb_riscv_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    riscv_multicycle_ctrl_if bus ();

    riscv_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        mr;
        logic        z;
        logic [16:0] exp;
    } step_t;

    step_t      q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [6:0] cur_op  = 7'b0000011;
    logic [2:0] cur_f3  = 3'b000;
    logic       cur_f7  = 1'b0;
    logic       pending_ill = 1'b0;

    // {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
    //  alu_src_a, alu_src_b, imm_src, alu_control, illegal}
    logic [16:0] obs;
    assign obs = {bus.pc_write, bus.adr_src, bus.ir_write, bus.mem_write, bus.reg_write,
                  bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
                  bus.alu_control, bus.illegal};

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic logic [16:0] vec(input logic pcw, input logic adr, input logic irw,
                                        input logic mw, input logic rw, input logic [1:0] rs,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] alu, input logic ill);
        return {pcw, adr, irw, mw, rw, rs, a, b, imm_of(cur_op), alu, ill};
    endfunction

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input string tag, input logic rst, input logic mr, input logic z,
                        input logic [16:0] e);
        step_t s;
        s.tag = tag; s.rst = rst; s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7;
        s.mr = mr; s.z = z; s.exp = e;
        q.push_back(s);
    endtask

    task automatic push_reset(input int n);
        for (int i = 0; i < n; i++)
            push("reset", 1'b0, rbit(), rbit(),
                 vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0));
        pending_ill = 1'b0;
    endtask

    task automatic push_fetch(input int waits);
        for (int i = 0; i < waits; i++) begin
            push("fetch_wait", 1'b1, 1'b0, rbit(),
                 vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, pending_ill));
            pending_ill = 1'b0;
        end
        push("fetch", 1'b1, 1'b1, rbit(),
             vec(1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, pending_ill));
        pending_ill = 1'b0;
    endtask

    task automatic begin_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input int fwaits);
        cur_op = o; cur_f3 = f3; cur_f7 = f7;
        push_fetch(fwaits);
        push("decode", 1'b1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0));
    endtask

    task automatic do_lw(input int fw, input int mwaits);
        begin_instr(7'b0000011, 3'b010, 1'b0, fw);
        push("lw_memadr", 1'b1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
        for (int i = 0; i < mwaits; i++)
            push("lw_memread_wait", 1'b1, 1'b0, rbit(), vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        push("lw_memread", 1'b1, 1'b1, rbit(), vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
        push("lw_memwb", 1'b1, rbit(), rbit(), vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0));
    endtask

    task automatic do_sw_head(input int fw);
        begin_instr(7'b0100011, 3'b010, 1'b0, fw);
        push("sw_memadr", 1'b1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0));
    endtask

    task automatic push_memwrite(input logic mr);
        push(mr ? "sw_memwrite" : "sw_memwrite_wait", 1'b1, mr, rbit(),
             vec(0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    endtask

    task automatic do_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input logic [2:0] exp_alu);
        begin_instr(o, f3, f7, 0);
        if (o == 7'b0110011)
            push("execr", 1'b1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, exp_alu, 0));
        else
            push("execi", 1'b1, rbit(), rbit(), vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, exp_alu, 0));
        push("aluwb", 1'b1, rbit(), rbit(), vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    endtask

    task automatic do_beq(input logic z);
        begin_instr(7'b1100011, 3'b000, 1'b0, 0);
        push(z ? "beq_taken" : "beq_not_taken", 1'b1, rbit(), z,
             vec(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0));
    endtask

    task automatic do_jal();
        begin_instr(7'b1101111, 3'b000, 1'b0, 0);
        push("jal", 1'b1, rbit(), rbit(), vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0));
        push("jal_aluwb", 1'b1, rbit(), rbit(), vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0));
    endtask

    task automatic do_illegal();
        begin_instr(7'b0000000, 3'b000, 1'b0, 0);
        pending_ill = 1'b1;
    endtask

    task automatic run_steps();
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            rst_n         = s.rst;
            bus.op        = s.op;
            bus.funct3    = s.f3;
            bus.funct7b5  = s.f7;
            bus.mem_ready = s.mr;
            bus.zero      = s.z;
            #1;
            chk(s.tag, obs, s.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.op = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
        bus.mem_ready = 1'b1; bus.zero = 1'b0;

        push_reset(2);
        do_lw(0, 0);
        do_sw_head(1);
        push_memwrite(1'b0); push_memwrite(1'b0); push_memwrite(1'b0); push_memwrite(1'b1);
        do_alu(7'b0110011, 3'b000, 1'b1, 3'b001);
        do_alu(7'b0110011, 3'b000, 1'b0, 3'b000);
        do_alu(7'b0010011, 3'b000, 1'b1, 3'b000);
        do_alu(7'b0110011, 3'b110, 1'b0, 3'b011);
        do_alu(7'b0010011, 3'b111, 1'b0, 3'b010);
        do_alu(7'b0110011, 3'b010, 1'b0, 3'b101);
        do_alu(7'b0010011, 3'b100, 1'b1, 3'b000);
        do_beq(1'b1);
        do_beq(1'b0);
        do_jal();
        do_illegal();
        do_lw(1, 2);
        do_sw_head(0);
        push_memwrite(1'b0);
        push_memwrite(1'b0);
        push_reset(2);
        do_lw(0, 0);
        do_illegal();
        push_reset(1);
        do_beq(1'b1);
        do_illegal();
        do_jal();
        run_steps();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Moore-style main controller that turns the shared 32-bit datapath (PC/ALU/memory plus its 2:1 and 3:1 selection muxes) into a multi-cycle RV32I subset core. It decodes the latched instruction, walks a per-instruction state sequence, and drives every mux select, register-enable and memory strobe. One shared memory port serves both fetch and data access. A ready handshake stretches memory states.

## Interface
Parameters:
- none; the opcode set and encodings below are fixed.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- op  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12]
- funct7b5  input  1  instr[30]
- zero  input  1  ALU zero flag, same cycle
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  PC register enable
- adr_src  output  1  memory address mux select: 0 = PC, 1 = ALUOut
- ir_write  output  1  instruction and old-PC register enable
- mem_write  output  1  memory write strobe
- reg_write  output  1  register file write enable
- result_src  output  2  result mux select: 00 = ALUOut, 01 = read data, 10 = ALU result
- alu_src_a  output  2  ALU A mux select: 00 = PC, 01 = old PC, 10 = rs1
- alu_src_b  output  2  ALU B mux select: 00 = rs2, 01 = immediate, 10 = constant 4
- imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  output  1  one-cycle registered pulse on an unsupported opcode

## Operation
- State register, 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Encodings 11–15 go to FETCH.
- Per-state outputs. Any output not listed is 0. Default selects are 00.
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10. ir_write=pc_write=mem_ready. Hold while !mem_ready; else go to DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, add (branch/jump target into ALUOut).
    - 0000011 or 0100011 go to MEMADR.
    - 0110011 goes to EXECR. 0010011 goes to EXECI.
    - 1101111 goes to JAL. 1100011 goes to BEQ.
    - Any other opcode goes to FETCH and sets illegal for the next cycle.
  - MEMADR: alu_src_a=10, alu_src_b=01, add. op[5]=0 goes to MEMREAD; op[5]=1 goes to MEMWRITE.
  - MEMREAD: adr_src=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: result_src=01, reg_write=1, then go to FETCH.
  - MEMWRITE: adr_src=1, mem_write=1 for the whole state. Hold until mem_ready, then go to FETCH.
  - EXECR: alu_src_a=10, alu_src_b=00, funct decode, then go to ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, funct decode, then go to ALUWB.
  - ALUWB: result_src=00, reg_write=1, then go to FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 (PC ← target), then go to ALUWB (rd ← old PC + 4).
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero, then go to FETCH.
- Funct decode, used in EXECR and EXECI. Any other funct3 gives add.
  - funct3 000: sub if op[5]&funct7b5, else add.
  - funct3 010: slt. funct3 110: or. funct3 111: and.
- imm_src is a pure function of op in every state:
  - 0100011 gives 01; 1100011 gives 10; 1101111 gives 11; otherwise 00.

## Timing
- Reset (rst_n low):
  - State goes to FETCH immediately. illegal clears to 0.
  - pc_write, ir_write, mem_write and reg_write are forced 0 combinationally.
  - Selects show FETCH values: adr_src=0, alu_src_a=00, alu_src_b=10, result_src=10, alu_control=000.
- Reset release: the first fetch may complete at the first rising edge with rst_n high and mem_ready high.
- Reset mid-instruction aborts the sequence. No write strobe appears after the asserting edge.
- Zero-wait latency in cycles: lw 5, sw 4, R-type 4, I-type ALU 4, jal 4, beq 3, illegal 2. Each !mem_ready cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- mem_write stays stable through a stalled MEMWRITE. Only one memory transaction is in flight.
- All outputs except illegal are combinational from state and inputs. No output depends on mem_ready except pc_write and ir_write in FETCH.

## Test plan
- Reset: rst_n=0 mid-MEMWRITE → mem_write drops at once; state=FETCH; illegal=0; after release with mem_ready=1 → ir_write=1 on the first cycle.
- lw, op=0000011, mem_ready tied 1 → states 0,1,2,3,4,0; MEMWB gives result_src=01, reg_write=1; imm_src=00 throughout.
- sw with 3 wait cycles, op=0100011 → MEMWRITE lasts 4 cycles with mem_write=1, adr_src=1; total 7 cycles; reg_write never 1.
- R-type sub, op=0110011, funct3=000, funct7b5=1 → EXECR alu_control=001. addi with funct7b5=1, op=0010011 → alu_control=000. funct3=110 → 011.
- beq: zero=1 → BEQ pc_write=1, alu_control=001; zero=0 → pc_write=0; both return to FETCH after 3 cycles. jal → pc_write in JAL, then ALUWB reg_write=1.
- Illegal op=0000000 → DECODE→FETCH; illegal=1 for exactly the following cycle; no write strobes.
